ll_rx_frame_parser: RTL and testbench
=====================================

Name: ll_rx_frame_parser

Overview:
Receive-side counterpart of the client's LocalLink transmit path. Consumes byte-wide frames from the MAC rx LocalLink port, checks the destination MAC and ethertype, and extracts the 1-byte length field. Delivers exactly that many payload bytes to user logic with a valid strobe, then reports frame completion or error. There is no rx_dest_rdy, so every qualified beat is accepted; the block never back-pressures.

Parameters:
MY_MAC, 48'h000A35000001, station address; frames to this address or to broadcast FF:FF:FF:FF:FF:FF are accepted
ETHERTYPE, 16'h88B5, required ethertype, MSB first on the wire
MAX_LEN, 8'd200, largest legal payload length

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_data  input  8  rx LocalLink data byte
rx_sof  input  1  start of frame, active-high, qualified by rx_src_rdy
rx_eof  input  1  end of frame, active-high, qualified by rx_src_rdy
rx_src_rdy  input  1  beat valid
pl_data  output  8  payload byte
pl_valid  output  1  pl_data valid, one cycle per byte
rx_length  output  8  length field of the current or last frame
rx_src_mac  output  48  source MAC of the current or last frame
frame_done  output  1  1-cycle pulse: good frame fully received
frame_err  output  1  1-cycle pulse: frame aborted
err_code  output  2  1=truncated, 2=length>MAX_LEN, 3=sof inside frame; held until next error
busy  output  1  high from the sof beat until done, error, or drop completes

Behaviour:
- Beat = cycle with rx_src_rdy=1. Non-beat cycles change nothing.
- Wire format: bytes 0-5 dst MAC, 6-11 src MAC, 12-13 ethertype, 14 length L, then L payload bytes, then optional pad until eof.
- Reset: state IDLE, counters 0, every output 0.
- States: IDLE, HDR, PAYLOAD, PAD, DROP.
- IDLE: a beat with sof loads byte 0 and moves to HDR (hdr_cnt=1). Non-sof beats are ignored, which covers the tail of a frame cut by reset.
- HDR: hdr_cnt is 4 bits, 0..14.
  - dst bytes are compared on the fly against MY_MAC and broadcast.
  - src bytes shift into rx_src_mac.
  - Ethertype is compared on the fly.
  - At byte 14, rx_length<=L, and the next state is decided:
    - dst or ethertype mismatch -> DROP (silent: no done, no err).
    - L>MAX_LEN -> frame_err, code 2, then DROP.
    - L=0 with eof on this beat -> frame_done.
    - L=0 without eof -> PAD.
    - Otherwise -> PAYLOAD, pl_cnt=L.
- PAYLOAD: each beat drives pl_data/pl_valid on the next cycle (1-cycle registered latency) and decrements pl_cnt. On the last byte: with eof -> frame_done, same cycle as that byte's pl_valid; without eof -> PAD.
- PAD: discard beats until eof, then frame_done one cycle after the eof beat.
- DROP: discard beats until eof, then IDLE with no pulse.
- eof in HDR, or in PAYLOAD before pl_cnt reaches 1 -> frame_err code 1, then IDLE. Bytes already delivered stay delivered.
- sof in HDR/PAYLOAD/PAD/DROP -> frame_err code 3 one cycle later (HDR/PAYLOAD/PAD only; DROP restarts silently). The sof beat is reparsed as byte 0 of a new frame, so busy stays high.
- sof and eof on the same beat in IDLE: a 1-byte frame -> frame_err code 1.
- frame_done and frame_err are mutually exclusive per frame. Both drop busy on the pulse cycle unless a new sof was taken.
- rx_src_mac and rx_length update during the header and are stable from frame_done until the next header.
- Reset mid-frame: immediate IDLE, pl_valid cleared, no pulses.

Decomposition:
- Shared package ll_pkg: state encoding, HDR_BYTES=15, err_code constants (ERR_TRUNC, ERR_LEN, ERR_SOF), BCAST_MAC. The transmit side reuses the header offsets from it.
- One natural sub-module: ll_hdr_match. It takes hdr_cnt and byte and produces dst_ok, type_ok, and the src MAC shift. The FSM/counter stays in the top level.

Test Plan:
- dst=MY_MAC, type 88B5, L=0x0C, 12 bytes E0..EB, eof on the last byte -> pl_valid 12 cycles with E0..EB, frame_done the same cycle as the EB output, rx_length=0x0C.
- Same frame with rx_src_rdy toggling 1/0 -> identical payload and pulses, each pl_valid one cycle after its beat.
- L=4 followed by 41 pad bytes (60-byte frame) -> 4 payload bytes, no pad output, frame_done one cycle after eof.
- dst=00:11:22:33:44:55 or ethertype 0800 -> no pl_valid, no pulses, busy drops after eof; next valid frame parses normally.
- L=0xF0 > MAX_LEN -> frame_err, err_code=2, no payload; eof after 8 payload bytes of an L=12 frame -> 8 bytes out, frame_err with err_code=1.
- sof at payload byte 3 of frame A, then a good frame B -> frame_err with err_code=3, then B's payload and frame_done; reset asserted mid-payload -> outputs 0, tail ignored.

Source files
------------

// File: rtl/ll_pkg.sv
// Shared LocalLink frame definitions: parser states, header layout, error codes.
// The transmit path reuses the header offsets defined here.
package ll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_PAD,
        ST_DROP
    } ll_state_t;

    localparam int unsigned HDR_BYTES = 15;
    localparam int unsigned DST_OFS   = 0;
    localparam int unsigned SRC_OFS   = 6;
    localparam int unsigned TYPE_OFS  = 12;
    localparam int unsigned LEN_OFS   = 14;

    localparam logic [1:0] ERR_TRUNC = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_SOF   = 2'd3;

    localparam logic [47:0] BCAST_MAC = '1;

    // Byte idx (0 = first on the wire) of a MAC address, valid for idx 0..5.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
        logic [47:0] sh;
        sh = mac << (8 * idx);
        return sh[47:40];
    endfunction

endpackage

// File: rtl/ll_hdr_match.sv
// Header byte checker: accumulates destination/ethertype matches and shifts in
// the source MAC as header bytes arrive.
module ll_hdr_match
    import ll_pkg::*;
#(
    parameter logic [47:0] MY_MAC    = 48'h000A35000001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hdr_en,
    input  logic [3:0]  hdr_idx,
    input  logic [7:0]  hdr_byte,
    output logic        dst_ok,
    output logic        type_ok,
    output logic [47:0] src_mac
);

    logic uni_ok;
    logic bc_ok;
    logic uni_hit;
    logic bc_hit;

    assign uni_hit = (hdr_byte == mac_byte(MY_MAC, hdr_idx));
    assign bc_hit  = (hdr_byte == mac_byte(BCAST_MAC, hdr_idx));
    assign dst_ok  = uni_ok | bc_ok;

    // Byte 0 re-seeds the match flags so a restarted frame never inherits old results.
    always_ff @(posedge clk) begin
        if (reset) begin
            uni_ok  <= 1'b0;
            bc_ok   <= 1'b0;
            type_ok <= 1'b0;
            src_mac <= '0;
        end else if (hdr_en) begin
            if (hdr_idx == 4'(DST_OFS)) begin
                uni_ok <= uni_hit;
                bc_ok  <= bc_hit;
            end else if (hdr_idx < 4'(SRC_OFS)) begin
                uni_ok <= uni_ok & uni_hit;
                bc_ok  <= bc_ok & bc_hit;
            end else if (hdr_idx < 4'(TYPE_OFS)) begin
                src_mac <= {src_mac[39:0], hdr_byte};
            end else if (hdr_idx == 4'(TYPE_OFS)) begin
                type_ok <= (hdr_byte == ETHERTYPE[15:8]);
            end else if (hdr_idx == 4'(TYPE_OFS + 1)) begin
                type_ok <= type_ok & (hdr_byte == ETHERTYPE[7:0]);
            end
        end
    end

endmodule

// File: rtl/ll_rx_frame_parser.sv
// LocalLink receive frame parser: filters on destination MAC and ethertype,
// extracts the length byte and delivers that many payload bytes.
module ll_rx_frame_parser
    import ll_pkg::*;
#(
    parameter logic [47:0] MY_MAC    = 48'h000A35000001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [7:0]  MAX_LEN   = 8'd200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic        rx_src_rdy,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic [7:0]  rx_length,
    output logic [47:0] rx_src_mac,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    ll_state_t  state, state_nxt;
    logic [3:0] hdr_cnt, hdr_cnt_nxt;
    logic [7:0] pl_cnt, pl_cnt_nxt;
    logic [7:0] len_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic       done_nxt;
    logic       err_nxt;
    logic [1:0] code_nxt;
    logic       dst_ok;
    logic       type_ok;
    logic       hdr_en;
    logic [3:0] hdr_idx;
    logic       last_hdr;

    // Any sof beat is header byte 0, whatever state the parser was in.
    assign hdr_en   = rx_src_rdy & (rx_sof | (state == ST_HDR));
    assign hdr_idx  = rx_sof ? '0 : hdr_cnt;
    assign last_hdr = (hdr_cnt == 4'(HDR_BYTES - 1));
    assign busy     = (state != ST_IDLE);

    ll_hdr_match #(
        .MY_MAC    (MY_MAC),
        .ETHERTYPE (ETHERTYPE)
    ) u_hdr_match (
        .clk      (clk),
        .reset    (reset),
        .hdr_en   (hdr_en),
        .hdr_idx  (hdr_idx),
        .hdr_byte (rx_data),
        .dst_ok   (dst_ok),
        .type_ok  (type_ok),
        .src_mac  (rx_src_mac)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hdr_cnt    <= '0;
            pl_cnt     <= '0;
            rx_length  <= '0;
            pl_data    <= '0;
            pl_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
        end else begin
            state      <= state_nxt;
            hdr_cnt    <= hdr_cnt_nxt;
            pl_cnt     <= pl_cnt_nxt;
            rx_length  <= len_nxt;
            pl_data    <= data_nxt;
            pl_valid   <= valid_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            err_code   <= code_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hdr_cnt_nxt = hdr_cnt;
        pl_cnt_nxt  = pl_cnt;
        len_nxt     = rx_length;
        data_nxt    = pl_data;
        valid_nxt   = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        code_nxt    = err_code;
        if (rx_src_rdy) begin
            if (rx_sof) begin
                if (state inside {ST_HDR, ST_PAYLOAD, ST_PAD}) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_SOF;
                end
                if (rx_eof) begin
                    state_nxt   = ST_IDLE;
                    hdr_cnt_nxt = '0;
                    if (state == ST_IDLE) begin
                        err_nxt  = 1'b1;
                        code_nxt = ERR_TRUNC;
                    end
                end else begin
                    state_nxt   = ST_HDR;
                    hdr_cnt_nxt = 4'd1;
                end
            end else begin
                case (state)
                    ST_HDR: begin
                        if (last_hdr) begin
                            hdr_cnt_nxt = '0;
                            len_nxt     = rx_data;
                            if (!(dst_ok && type_ok)) begin
                                state_nxt = rx_eof ? ST_IDLE : ST_DROP;
                            end else if (rx_data > MAX_LEN) begin
                                err_nxt   = 1'b1;
                                code_nxt  = ERR_LEN;
                                state_nxt = rx_eof ? ST_IDLE : ST_DROP;
                            end else if (rx_data == 8'd0) begin
                                done_nxt  = rx_eof;
                                state_nxt = rx_eof ? ST_IDLE : ST_PAD;
                            end else if (rx_eof) begin
                                err_nxt   = 1'b1;
                                code_nxt  = ERR_TRUNC;
                                state_nxt = ST_IDLE;
                            end else begin
                                pl_cnt_nxt = rx_data;
                                state_nxt  = ST_PAYLOAD;
                            end
                        end else if (rx_eof) begin
                            hdr_cnt_nxt = '0;
                            err_nxt     = 1'b1;
                            code_nxt    = ERR_TRUNC;
                            state_nxt   = ST_IDLE;
                        end else begin
                            hdr_cnt_nxt = hdr_cnt + 4'd1;
                        end
                    end
                    ST_PAYLOAD: begin
                        data_nxt   = rx_data;
                        valid_nxt  = 1'b1;
                        pl_cnt_nxt = pl_cnt - 8'd1;
                        if (pl_cnt == 8'd1) begin
                            done_nxt  = rx_eof;
                            state_nxt = rx_eof ? ST_IDLE : ST_PAD;
                        end else if (rx_eof) begin
                            err_nxt   = 1'b1;
                            code_nxt  = ERR_TRUNC;
                            state_nxt = ST_IDLE;
                        end
                    end
                    ST_PAD: begin
                        if (rx_eof) begin
                            done_nxt  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (rx_eof) state_nxt = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ll_rx_frame_parser.sv
// Self-checking bench for ll_rx_frame_parser: table-driven frames, hand-written
// corner sequences and random frames checked against a frame-level model.
module tb_ll_rx_frame_parser;

    localparam logic [47:0] MY_MAC = 48'h000A35000001;
    localparam logic [47:0] BC_MAC = 48'hFFFFFFFFFFFF;
    localparam logic [15:0] ET     = 16'h88B5;
    localparam int          MAXL   = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_sof, rx_eof, rx_src_rdy;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic [7:0]  rx_length;
    logic [47:0] rx_src_mac;
    logic        frame_done, frame_err;
    logic [1:0]  err_code;
    logic        busy;

    always #5 clk = ~clk;

    ll_rx_frame_parser #(
        .MY_MAC    (MY_MAC),
        .ETHERTYPE (ET),
        .MAX_LEN   (8'd200)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .rx_src_rdy (rx_src_rdy),
        .pl_data    (pl_data),
        .pl_valid   (pl_valid),
        .rx_length  (rx_length),
        .rx_src_mac (rx_src_mac),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Frame under test and the cycle each of its beats was presented.
    logic [7:0]  fb[$];
    bit          fs[$], fe[$];
    int unsigned bcyc[0:599];

    // What the DUT produced, stamped with the cycle it was observed.
    logic [7:0]  got_pl[$];
    int unsigned got_plc[$];
    int          got_ev[$];
    int unsigned got_evc[$];

    // Values the outputs must hold between frames.
    logic [1:0]  exp_code = '0;
    logic [7:0]  exp_len  = '0;
    logic [47:0] exp_src  = '0;

    always @(negedge clk) begin
        if (pl_valid) begin
            got_pl.push_back(pl_data);
            got_plc.push_back(cyc);
        end
        if (frame_done) begin
            got_ev.push_back(1);
            got_evc.push_back(cyc);
        end
        if (frame_err) begin
            got_ev.push_back(2);
            got_evc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_src_rdy = 1'b0;
            rx_data    = 8'($urandom);
            rx_sof     = 1'($urandom);
            rx_eof     = 1'($urandom);
        end
    endtask

    task automatic clear_obs();
        got_pl.delete();
        got_plc.delete();
        got_ev.delete();
        got_evc.delete();
    endtask

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] len,
                         input int total, input bit rnd);
        logic [47:0] s;
        logic [7:0]  b;
        s[47:32] = 16'($urandom);
        s[31:0]  = $urandom;
        fb.delete();
        fs.delete();
        fe.delete();
        for (int i = 0; i < total; i++) begin
            if (i < 6)                   b = dst[8*(5-i) +: 8];
            else if (i < 12)             b = s[8*(11-i) +: 8];
            else if (i == 12)            b = et[15:8];
            else if (i == 13)            b = et[7:0];
            else if (i == 14)            b = len;
            else if (i < 15 + int'(len)) b = rnd ? 8'($urandom) : 8'(8'hE0 + i - 15);
            else                         b = 8'($urandom);
            fb.push_back(b);
            fs.push_back(i == 0);
            fe.push_back(i == total - 1);
        end
    endtask

    // gap: 0 back-to-back beats, 1 alternate idle cycles, 2 random idles.
    task automatic drive(input int lo, input int hi, input int gap);
        for (int i = lo; i <= hi; i++) begin
            if (i != lo) begin
                if (gap == 1) idle(1);
                else if (gap == 2) idle($urandom_range(0, 2));
            end
            @(negedge clk);
            rx_src_rdy = 1'b1;
            rx_data    = fb[i];
            rx_sof     = fs[i];
            rx_eof     = fe[i];
            bcyc[i]    = cyc;
        end
    endtask

    // Frame-level reference: decide the outcome from the frame contents alone.
    task automatic check_frame(input string tag);
        int          n, last, ev, ev_idx;
        int          exp_idx[$];
        logic [47:0] dst;
        bit          addr_ok;
        n  = fb.size();
        ev = 0;
        ev_idx = n - 1;
        for (int i = 6; i <= 11 && i < n; i++) exp_src = {exp_src[39:0], fb[i]};
        if (n < 15) begin
            ev = 2;
            exp_code = 2'd1;
        end else begin
            dst = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
            addr_ok = (dst == MY_MAC || dst == BC_MAC) && ({fb[12], fb[13]} == ET);
            exp_len = fb[14];
            if (!addr_ok) begin
                ev = 0;
            end else if (int'(fb[14]) > MAXL) begin
                ev = 2;
                ev_idx = 14;
                exp_code = 2'd2;
            end else begin
                last = 14 + int'(fb[14]);
                for (int i = 15; i <= last && i < n; i++) exp_idx.push_back(i);
                if (n - 1 < last) begin
                    ev = 2;
                    exp_code = 2'd1;
                end else begin
                    ev = 1;
                end
            end
        end
        chk({tag, ":npl"}, got_pl.size(), exp_idx.size());
        for (int k = 0; k < got_pl.size() && k < exp_idx.size(); k++) begin
            chk({tag, ":pl_data"}, got_pl[k], fb[exp_idx[k]]);
            chk({tag, ":pl_cyc"}, got_plc[k], bcyc[exp_idx[k]] + 1);
        end
        chk({tag, ":nev"}, got_ev.size(), (ev != 0) ? 1 : 0);
        if (ev != 0 && got_ev.size() > 0) begin
            chk({tag, ":ev"}, got_ev[0], ev);
            chk({tag, ":ev_cyc"}, got_evc[0], bcyc[ev_idx] + 1);
        end
        chk({tag, ":err_code"}, err_code, exp_code);
        chk({tag, ":rx_length"}, rx_length, exp_len);
        chk({tag, ":rx_src_mac"}, rx_src_mac, exp_src);
        chk({tag, ":busy"}, busy, 0);
    endtask

    task automatic run_frame(input string tag, input int gap);
        clear_obs();
        drive(0, fb.size() - 1, gap);
        idle(4);
        check_frame(tag);
    endtask

    typedef struct {
        logic [47:0] dst;
        logic [15:0] et;
        logic [7:0]  len;
        int          total;
        int          gap;
        int          ev;
        int          npl;
        logic [1:0]  code;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [7:0]  qa[$];
        bit          qs[$], qe[$];
        logic [47:0] d;
        logic [15:0] et;
        logic [7:0]  l;
        int          tot;

        reset = 1'b1;
        rx_src_rdy = 1'b0;
        rx_data = '0;
        rx_sof = 1'b0;
        rx_eof = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:pl_valid", pl_valid, 0);
        chk("rst:pl_data", pl_data, 0);
        chk("rst:busy", busy, 0);
        chk("rst:frame_done", frame_done, 0);
        chk("rst:frame_err", frame_err, 0);
        chk("rst:err_code", err_code, 0);
        chk("rst:rx_length", rx_length, 0);
        chk("rst:rx_src_mac", rx_src_mac, 0);
        reset = 1'b0;
        idle(2);

        //            dst                  et        len    tot  gap ev npl code
        vt.push_back('{MY_MAC,             ET,       8'd12, 27,  0,  1, 12, 2'd0});
        vt.push_back('{MY_MAC,             ET,       8'd12, 27,  1,  1, 12, 2'd0});
        vt.push_back('{MY_MAC,             ET,       8'd4,  60,  0,  1, 4,  2'd0});
        vt.push_back('{48'h001122334455,   ET,       8'd12, 27,  0,  0, 0,  2'd0});
        vt.push_back('{MY_MAC,             16'h0800, 8'd12, 27,  0,  0, 0,  2'd0});
        vt.push_back('{BC_MAC,             ET,       8'd5,  20,  2,  1, 5,  2'd0});
        vt.push_back('{MY_MAC,             ET,       8'hF0, 40,  0,  2, 0,  2'd2});
        vt.push_back('{MY_MAC,             ET,       8'd12, 23,  0,  2, 8,  2'd1});
        vt.push_back('{MY_MAC,             ET,       8'd0,  15,  0,  1, 0,  2'd1});
        vt.push_back('{MY_MAC,             ET,       8'd0,  20,  1,  1, 0,  2'd1});
        vt.push_back('{MY_MAC,             ET,       8'd12, 10,  0,  2, 0,  2'd1});
        vt.push_back('{MY_MAC,             ET,       8'd200, 215, 0, 1, 200, 2'd1});
        vt.push_back('{MY_MAC,             ET,       8'd201, 230, 0, 2, 0,  2'd2});
        vt.push_back('{MY_MAC,             ET,       8'd3,  1,   0,  2, 0,  2'd1});
        vt.push_back('{MY_MAC,             ET,       8'd1,  15,  0,  2, 0,  2'd1});
        vt.push_back('{MY_MAC,             ET,       8'd12, 27,  2,  1, 12, 2'd1});

        for (int v = 0; v < vt.size(); v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            build(vt[v].dst, vt[v].et, vt[v].len, vt[v].total, 1'b0);
            run_frame(tag, vt[v].gap);
            chk({tag, ":tbl_ev"}, (got_ev.size() == 0) ? 0 : got_ev[0], vt[v].ev);
            chk({tag, ":tbl_npl"}, got_pl.size(), vt[v].npl);
            chk({tag, ":tbl_code"}, err_code, vt[v].code);
            if (v == 0 && got_pl.size() == 12) begin
                chk("vec0:first", got_pl[0], 8'hE0);
                chk("vec0:last", got_pl[11], 8'hEB);
            end
        end

        // sof at payload byte 3 of frame A, then a complete good frame B
        build(MY_MAC, ET, 8'd12, 27, 1'b0);
        qa = fb[0:17];
        qs = fs[0:17];
        qe = fe[0:17];
        build(BC_MAC, ET, 8'd12, 27, 1'b0);
        fb = {qa, fb};
        fs = {qs, fs};
        fe = {qe, fe};
        clear_obs();
        drive(0, fb.size() - 1, 0);
        idle(4);
        chk("sof:npl", got_pl.size(), 15);
        if (got_pl.size() >= 4) begin
            chk("sof:a_last", got_pl[2], 8'hE2);
            chk("sof:b_first", got_pl[3], 8'hE0);
            chk("sof:b_first_cyc", got_plc[3], bcyc[33] + 1);
        end
        chk("sof:nev", got_ev.size(), 2);
        if (got_ev.size() >= 2) begin
            chk("sof:err", got_ev[0], 2);
            chk("sof:err_cyc", got_evc[0], bcyc[18] + 1);
            chk("sof:done", got_ev[1], 1);
            chk("sof:done_cyc", got_evc[1], bcyc[44] + 1);
        end
        exp_code = 2'd3;
        exp_len  = 8'd12;
        exp_src  = {fb[24], fb[25], fb[26], fb[27], fb[28], fb[29]};
        chk("sof:err_code", err_code, exp_code);
        chk("sof:rx_src_mac", rx_src_mac, exp_src);
        chk("sof:busy", busy, 0);

        // reset in the middle of the payload; the tail must be ignored
        build(MY_MAC, ET, 8'd12, 27, 1'b0);
        clear_obs();
        drive(0, 19, 0);
        @(negedge clk);
        chk("mid:busy", busy, 1);
        chk("mid:pl_valid", pl_valid, 1);
        chk("mid:pl_data", pl_data, fb[19]);
        rx_src_rdy = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid:npl", got_pl.size(), 5);
        chk("rstmid:pl_valid", pl_valid, 0);
        chk("rstmid:busy", busy, 0);
        chk("rstmid:err_code", err_code, 0);
        chk("rstmid:rx_length", rx_length, 0);
        chk("rstmid:rx_src_mac", rx_src_mac, 0);
        reset = 1'b0;
        exp_code = '0;
        exp_len  = '0;
        exp_src  = '0;
        clear_obs();
        drive(20, 26, 0);
        idle(4);
        chk("tail:npl", got_pl.size(), 0);
        chk("tail:nev", got_ev.size(), 0);
        chk("tail:busy", busy, 0);
        build(MY_MAC, ET, 8'd6, 21, 1'b1);
        run_frame("after_rst", 0);

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 3))
                0: d = MY_MAC;
                1: d = BC_MAC;
                2: d = {16'($urandom), $urandom};
                default: d = MY_MAC ^ (48'h1 << (8 * $urandom_range(0, 5)));
            endcase
            et = ($urandom_range(0, 9) == 0) ? 16'($urandom) : ET;
            l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
            if (int'(l) > MAXL) tot = 15 + $urandom_range(0, 5);
            else if ($urandom_range(0, 3) == 0) tot = $urandom_range(1, 15 + int'(l));
            else tot = 15 + int'(l) + $urandom_range(0, 5);
            build(d, et, l, tot, 1'b1);
            run_frame($sformatf("rnd%0d", r), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
